// File: rtl/sram_stream_reader.sv
// Read-side controller for the SRAM buffer: walks an address window on a
// 1-cycle synchronous read port and streams the words over ready/valid.
module sram_stream_reader #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] issue_cnt_q;
    logic [ADDR_W-1:0] beat_cnt_q;
    logic              inflight_q;
    logic              done_q;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic accept_c;
    logic credit_c;
    logic push_c;
    logic pop_c;
    logic last_pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit-based read issue: buffered words plus the word in flight never exceed the FIFO.
    always_comb begin
        accept_c   = (state_q == IDLE) && start && !abort;
        credit_c   = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
        mem_en     = (state_q == RUN) && credit_c;
        mem_addr   = rd_ptr_q;
        out_valid  = (count_q != '0);
        out_data   = out_valid ? fifo_mem[head_q] : '0;
        out_last   = out_valid && (beat_cnt_q == '0);
        push_c     = inflight_q && !abort;
        pop_c      = out_valid && out_ready && !abort;
        last_pop_c = pop_c && (beat_cnt_q == '0);
        busy       = (state_q != IDLE);
        done       = done_q;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (mem_en && (issue_cnt_q == '0)) state_d = DRAIN;
                DRAIN:   if (last_pop_c) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Address walker, issue and beat counters, in-flight flag, completion pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q <= mem_en && !abort;
            done_q     <= (state_q == DRAIN) && last_pop_c;
            if (accept_c) begin
                rd_ptr_q    <= base_addr;
                issue_cnt_q <= len_m1;
                beat_cnt_q  <= len_m1;
            end else begin
                if (mem_en) begin
                    rd_ptr_q    <= rd_ptr_q + ADDR_W'(1);
                    issue_cnt_q <= issue_cnt_q - ADDR_W'(1);
                end
                if (pop_c) beat_cnt_q <= beat_cnt_q - ADDR_W'(1);
            end
        end
    end

    // Output FIFO pointers and occupancy; abort flushes it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (abort) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_c) tail_q <= ptr_inc(tail_q);
            if (pop_c)  head_q <= ptr_inc(head_q);
            if (push_c && !pop_c)      count_q <= count_q + CNT_W'(1);
            else if (!push_c && pop_c) count_q <= count_q - CNT_W'(1);
        end
    end

    // FIFO storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clock) begin
        if (push_c) fifo_mem[tail_q] <= mem_data;
    end

    // A push into a full FIFO without a simultaneous pop would lose data.
    overflow_a: assert property (@(posedge clock) disable iff (!reset_n)
        !(push_c && !pop_c && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Read-side controller for the spectrometer's 256x32 dual-port SRAM buffer.
- On a start command it walks a programmable address window on the SRAM read port (R0: addr/en, 1-cycle synchronous read data).
- Read words are presented as a ready/valid stream with last-beat marking, under full backpressure.
- Sits between the SRAM wrapper's read port and the downstream readout/serializer stage.

Parameters:
- ADDR_W, 8, SRAM address width; depth = 2^ADDR_W.
- DATA_W, 32, SRAM and stream data width.
- FIFO_DEPTH, 3, output buffer entries; must be >= 3 for 1 word/cycle throughput.

Ports:
- clock  in  1  single clock for all logic; also clocks the SRAM read port.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; honoured only when busy=0.
- base_addr  in  ADDR_W  first word address, sampled with start.
- len_m1  in  ADDR_W  transfer length minus 1 (1..256 words), sampled with start.
- abort  in  1  synchronous cancel of the current transfer.
- mem_addr  out  ADDR_W  SRAM read address (to R0_addr).
- mem_en  out  1  SRAM read enable (to R0_en).
- mem_data  in  DATA_W  SRAM read data (R0_data); valid the cycle after mem_en.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  DATA_W  stream data.
- out_last  out  1  marks the final word of the transfer.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async assert, sync-free deassert): state IDLE, FIFO empty, in-flight flag 0.
  - Outputs during reset: mem_en=0, mem_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
- States:
  - IDLE: start=1 latches base_addr into rd_ptr and len_m1 into issue_cnt and beat_cnt; go to RUN.
  - RUN: issue reads; go to DRAIN after the last read is issued.
  - DRAIN: wait until the last beat is accepted.
  - Leaving DRAIN: on the last beat, go to IDLE and pulse done the following cycle.
- busy=1 in RUN and DRAIN. start is ignored while busy=1.
- Read issue (combinational, no out_ready-to-mem_en path): mem_en = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH); mem_addr = rd_ptr.
- Each issued read:
  - rd_ptr increments modulo 2^ADDR_W (0xFF wraps to 0x00).
  - issue_cnt decrements; issuing at issue_cnt==0 moves to DRAIN.
- inflight is a registered copy of mem_en. When inflight=1, mem_data is written into the FIFO tail.
- Stream side:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - A beat transfers when out_valid && out_ready; it pops the FIFO and decrements beat_cnt.
  - out_last = out_valid && (beat_cnt==0).
  - out_data/out_valid are held stable while out_valid && !out_ready.
- Same-cycle FIFO push and pop is allowed at any occupancy, including full. The credit rule guarantees no overflow; an overflow is an assertion failure.
- Latency: start high in cycle 0 -> mem_en in cycle 1 -> data in FIFO end of cycle 2 -> out_valid in cycle 3.
- Throughput: with out_ready held high, one beat per cycle; an N-word transfer ends at cycle N+2.
- Backpressure: with out_ready low, at most FIFO_DEPTH reads are outstanding (buffered + in flight), then mem_en stays 0.
- len_m1=0 transfers one word, with out_last on that beat. len_m1=0xFF transfers 256 words, covering the whole memory once with wrap.
- abort (any state, highest priority after reset):
  - Next cycle: FIFO empty, inflight ignored (the returning word is discarded), state IDLE, busy=0.
  - No done pulse.
  - start in the same cycle as abort is ignored.
- done never coincides with busy=1. A new start is accepted in the cycle done is high.

Test Plan:
1. Single word: mem[0x10]=0xDEADBEEF; start with base=0x10, len_m1=0, out_ready=1 -> mem_en only in cycle 1 with addr 0x10; out_valid/out_last/0xDEADBEEF in cycle 3; done in cycle 4.
2. Full window with wrap: mem[i]=i; base=0xF0, len_m1=0xFF, ready=1 -> 256 consecutive beats with data 0xF0..0xFF,0x00..0xEF; out_last only on 0xEF; no bubbles.
3. Backpressure: base=0, len_m1=7, out_ready low for cycles 3-12 -> exactly 3 reads issued then mem_en=0; data held stable; after release, words 0..7 in order with none lost or duplicated.
4. Random out_ready (50%) over 1000 transfers with random base/length -> scoreboard matches memory contents; FIFO never overflows; exactly one out_last and one done per transfer.
5. Abort mid-transfer with a read in flight: len_m1=20, abort at beat 5 -> busy=0 and out_valid=0 next cycle, no done; an immediate new start returns only the new transfer's data.
6. Start while busy, plus async reset mid-transfer: a second start during RUN is ignored (count unchanged); reset_n low in DRAIN -> all outputs 0 immediately; after release, idle until the next start.
